cir_peak_detect: RTL and testbench
==================================

Name: cir_peak_detect

Overview:
- Sits directly downstream of the CIR averaging stage, inside the same RFNoC CE.
- Consumes averaged channel-impulse-response frames of seq_len complex samples (32-bit, I in [31:16], Q in [15:0], signed 16-bit each) on AXI-stream.
- For each frame, computes |x|² per sample and tracks the peak magnitude and its index.
- Emits one 2-word summary packet per frame: peak magnitude, then threshold flag, length-error flag, frame number and peak index.

Parameters:
- IDX_W, 10, width of sample index and seq_len; max frame length 2^IDX_W.
- FCNT_W, 16, width of the wrapping frame counter reported in word 1.

Ports:
- clk  in  1  CE clock.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous soft clear (block reset setting register); same effect as reset.
- seq_len  in  IDX_W  frame length in samples; 0 means 2^IDX_W.
- threshold  in  32  unsigned peak-detection threshold on |x|².
- i_tdata  in  32  {I[15:0],Q[15:0]} averaged CIR sample.
- i_tlast  in  1  last sample of frame.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  32  summary word.
- o_tlast  out  1  high on summary word 1.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- frame_count  out  FCNT_W  number of summary packets completed, for readback.

Behaviour:
- Reset/clear:
  - state=ACCUM, i_tready=1, o_tvalid=0, o_tlast=0, o_tdata=0, frame_count=0.
  - Pipeline, peak and index registers are zeroed.
  - Reset or clear mid-frame or mid-output abandons the frame with no partial output.
- seq_len is latched on the first accepted beat of each frame; changes mid-frame are ignored until the next frame.
- Stage 1 (registered):
  - mag = I*I + Q*Q, signed squares, unsigned 32-bit sum. Max is 2^31 at I=Q=-32768, so there is no overflow or saturation.
  - Registered alongside mag: idx (count of the beat within the frame, starting at 0), end flag, err flag.
- End of frame:
  - A beat ends the frame if i_tlast=1 or idx==len-1.
  - err=1 if exactly one of those conditions holds: early tlast, or tlast missing at the length boundary.
  - Either condition closes the frame; the next beat starts a new frame at idx 0.
- Stage 2 (compare):
  - idx==0 loads peak=mag, pidx=0.
  - Otherwise update only if mag > peak (strict), so the first occurrence wins ties.
  - err flags are OR-accumulated over the frame.
- FSM:
  - ACCUM: i_tready = !(stage-1 holds an end beat). After an end beat is accepted in cycle k, i_tready=0 at k+1; the compare completes at k+1; state=EMIT_MAG with o_tvalid=1 at k+2. Latency from last input beat to first output word is 2 cycles.
  - EMIT_MAG: o_tdata=final peak, o_tlast=0. On o_tvalid&&o_tready go to EMIT_IDX.
  - EMIT_IDX:
    - o_tdata = {above, err, 4'b0, frame_num[15:0], pidx[9:0]}; o_tlast=1.
    - above = (peak > threshold), strict.
    - frame_num = frame_count value before increment.
    - On handshake: frame_count += 1 (wraps at 2^FCNT_W), state=ACCUM, i_tready=1 next cycle.
- Output handshake:
  - o_tdata/o_tlast remain stable while o_tvalid=1 and o_tready=0.
  - i_tready stays 0 throughout EMIT_*, so no input beats are lost under backpressure.
- threshold is sampled in EMIT_IDX, the cycle word 1 is presented, and held stable while stalled.
- Single-sample frame (len=1, or tlast on beat 0): peak=that sample, pidx=0.
- Full-size frame: seq_len=0 gives frames of 1024 beats, pidx 0..1023.
- All-zero frame: peak=0, pidx=0, above=0 even when threshold=0, since the compare is strict.

Test Plan:
- seq_len=8; frame of 8 samples, all 0x00000000 except idx5=0x00030004 (3,4), tlast on beat 7; threshold=20; o_tready=1 → word0=0x00000019 (25), word1=0x80000005; o_tvalid rises 2 cycles after the last beat; frame_count=1.
- seq_len=4; samples with mags 9,16,16,4 (0x00030000, 0x00040000, 0x00000004, 0x00020000), tlast on beat 3; threshold=100 → word0=16, word1 pidx=1 (first max wins), above=0 → 0x00000001.
- seq_len=8, tlast on beat 2 (early), then a clean 8-beat frame → packet 1 word1 bit30=1 and frame_num=0; packet 2 bit30=0 and frame_num=1 (0x00000400|pidx).
- Sample 0x80008000 (-32768,-32768) in a 1-sample frame with tlast → word0=0x80000000 with no overflow; with threshold=0x7FFFFFFF, above=1.
- o_tready held low 10 cycles during EMIT_MAG, with i_tvalid=1 continuously → o_tdata stable, i_tready=0 throughout, no input beats accepted until word1 handshakes; the next frame's samples are all accounted for.
- clear pulsed at beat 3 of a 8-beat frame, then a full new frame → no packet for the aborted frame; the new packet reports frame_num=0 and correct peak/index.

Source files
------------

// File: rtl/cir_peak_detect.sv
// Peak detector for averaged CIR frames: tracks max |x|^2 and its index per frame
// and emits a two-word summary packet (peak magnitude, then flags/frame/index).
module cir_peak_detect #(
  parameter int IDX_W  = 10,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [IDX_W-1:0]  seq_len,
  input  logic [31:0]       threshold,
  input  logic [31:0]       i_tdata,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic [31:0]       o_tdata,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic [FCNT_W-1:0] frame_count
);

  localparam int DATA_W = 16;
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);

  typedef enum logic [1:0] {
    ACCUM    = 2'd0,
    EMIT_MAG = 2'd1,
    EMIT_IDX = 2'd2
  } state_t;

  // Squares are non-negative and each at most 2^30, so the sum fits in 32 unsigned bits.
  function automatic logic [31:0] mag_sq(input logic signed [DATA_W-1:0] i_s,
                                         input logic signed [DATA_W-1:0] q_s);
    logic signed [31:0] ii;
    logic signed [31:0] qq;
    ii = i_s * i_s;
    qq = q_s * q_s;
    return $unsigned(ii) + $unsigned(qq);
  endfunction

  state_t             state_q, state_d;
  logic               rst_any;

  logic [IDX_W-1:0]   frm_idx_q, frm_idx_d;
  logic               in_frame_q, in_frame_d;
  logic [IDX_W-1:0]   len_q, len_d;

  logic               vld_p1_q, vld_p1_d;
  logic [31:0]        mag_p1_q, mag_p1_d;
  logic [IDX_W-1:0]   idx_p1_q, idx_p1_d;
  logic               end_p1_q, end_p1_d;
  logic               err_p1_q, err_p1_d;

  logic [31:0]        peak_p2_q, peak_p2_d;
  logic [IDX_W-1:0]   pidx_p2_q, pidx_p2_d;
  logic               err_p2_q, err_p2_d;

  logic [FCNT_W-1:0]  frame_count_q, frame_count_d;

  logic               beat_acc;
  logic [IDX_W-1:0]   len_sel;
  logic [IDX_W-1:0]   last_idx;
  logic               at_len;
  logic               end_p0;
  logic               err_p0;
  logic               above;
  logic [31:0]        word1;

  assign rst_any = reset | clear;

  // Stage 0: beat acceptance, frame index and end-of-frame decode
  always_comb begin
    i_tready = (state_q == ACCUM) && !(vld_p1_q && end_p1_q);
    beat_acc = i_tvalid && i_tready;
    // seq_len is only looked at on the first beat; 0 wraps to 2^IDX_W-1 as last index
    len_sel  = in_frame_q ? len_q : seq_len;
    last_idx = len_sel - IDX_ONE;
    at_len   = (frm_idx_q == last_idx);
    end_p0   = i_tlast | at_len;
    err_p0   = i_tlast ^ at_len;

    frm_idx_d  = frm_idx_q;
    in_frame_d = in_frame_q;
    len_d      = len_q;
    if (beat_acc) begin
      len_d = len_sel;
      if (end_p0) begin
        frm_idx_d  = '0;
        in_frame_d = 1'b0;
      end else begin
        frm_idx_d  = frm_idx_q + IDX_ONE;
        in_frame_d = 1'b1;
      end
    end
  end

  // Stage 1: magnitude and per-beat flags
  always_comb begin
    vld_p1_d = beat_acc;
    mag_p1_d = mag_p1_q;
    idx_p1_d = idx_p1_q;
    end_p1_d = end_p1_q;
    err_p1_d = err_p1_q;
    if (beat_acc) begin
      mag_p1_d = mag_sq(i_tdata[31:16], i_tdata[15:0]);
      idx_p1_d = frm_idx_q;
      end_p1_d = end_p0;
      err_p1_d = err_p0;
    end
  end

  // Stage 2: running peak compare (strict, so the first maximum keeps the index)
  always_comb begin
    peak_p2_d = peak_p2_q;
    pidx_p2_d = pidx_p2_q;
    err_p2_d  = err_p2_q;
    if (vld_p1_q) begin
      if (idx_p1_q == '0) begin
        peak_p2_d = mag_p1_q;
        pidx_p2_d = '0;
        err_p2_d  = err_p1_q;
      end else begin
        err_p2_d = err_p2_q | err_p1_q;
        if (mag_p1_q > peak_p2_q) begin
          peak_p2_d = mag_p1_q;
          pidx_p2_d = idx_p1_q;
        end
      end
    end
  end

  // Output FSM
  always_comb begin
    state_d       = state_q;
    frame_count_d = frame_count_q;
    o_tvalid      = 1'b0;
    o_tlast       = 1'b0;
    o_tdata       = '0;
    above         = (peak_p2_q > threshold);
    word1         = {above, err_p2_q, 4'b0000, 16'(frame_count_q), 10'(pidx_p2_q)};
    case (state_q)
      ACCUM: begin
        if (vld_p1_q && end_p1_q) state_d = EMIT_MAG;
      end
      EMIT_MAG: begin
        o_tvalid = 1'b1;
        o_tdata  = peak_p2_q;
        if (o_tready) state_d = EMIT_IDX;
      end
      EMIT_IDX: begin
        o_tvalid = 1'b1;
        o_tlast  = 1'b1;
        o_tdata  = word1;
        if (o_tready) begin
          state_d       = ACCUM;
          frame_count_d = frame_count_q + FCNT_ONE;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  assign frame_count = frame_count_q;

  always_ff @(posedge clk) begin
    if (rst_any) begin
      state_q       <= ACCUM;
      frm_idx_q     <= '0;
      in_frame_q    <= 1'b0;
      len_q         <= '0;
      vld_p1_q      <= 1'b0;
      mag_p1_q      <= '0;
      idx_p1_q      <= '0;
      end_p1_q      <= 1'b0;
      err_p1_q      <= 1'b0;
      peak_p2_q     <= '0;
      pidx_p2_q     <= '0;
      err_p2_q      <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      frm_idx_q     <= frm_idx_d;
      in_frame_q    <= in_frame_d;
      len_q         <= len_d;
      vld_p1_q      <= vld_p1_d;
      mag_p1_q      <= mag_p1_d;
      idx_p1_q      <= idx_p1_d;
      end_p1_q      <= end_p1_d;
      err_p1_q      <= err_p1_d;
      peak_p2_q     <= peak_p2_d;
      pidx_p2_q     <= pidx_p2_d;
      err_p2_q      <= err_p2_d;
      frame_count_q <= frame_count_d;
    end
  end

endmodule

// File: tb/tb_cir_peak_detect.sv
// Directed bench for cir_peak_detect: hand-computed summary packets per frame.
module tb_cir_peak_detect;

  logic        clk;
  logic        reset;
  logic        clear;
  logic [9:0]  seq_len;
  logic [31:0] threshold;
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic [15:0] frame_count;

  int n_checks;
  int n_fail;
  logic [31:0] frm [1024];
  logic [31:0] w0, w1;

  cir_peak_detect #(.IDX_W(10), .FCNT_W(16)) dut (
    .clk(clk), .reset(reset), .clear(clear), .seq_len(seq_len),
    .threshold(threshold), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .i_tready(i_tready), .o_tdata(o_tdata),
    .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [31:0] d, input logic l);
    bit done;
    done = 1'b0;
    i_tdata  = d;
    i_tlast  = l;
    i_tvalid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (i_tready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    if (!done) check("send_timeout", 32'(i_tready), 32'd1);
  endtask

  task automatic send_frame(input int n, input bit tl);
    for (int b = 0; b < n; b++) send(frm[b], tl && (b == n - 1));
  endtask

  task automatic zero_frame();
    for (int b = 0; b < 1024; b++) frm[b] = 32'h0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  // Collects one summary packet with o_tready high; returns at posedge+1.
  task automatic recv(input string tag, output logic [31:0] r0, output logic [31:0] r1);
    bit seen;
    seen = 1'b0;
    r0 = '0;
    r1 = '0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      if (o_tvalid) seen = 1'b1;
    end
    if (!seen) check({tag, "_timeout"}, 32'(o_tvalid), 32'd1);
    else begin
      check({tag, "_w0_last"}, 32'(o_tlast), 32'd0);
      r0 = o_tdata;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_w1_valid"}, 32'(o_tvalid), 32'd1);
      check({tag, "_w1_last"}, 32'(o_tlast), 32'd1);
      r1 = o_tdata;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; clear = 1'b0; seq_len = 10'd8; threshold = 32'd20;
    i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_tready", 32'(i_tready), 32'd1);
    check("rst_tvalid", 32'(o_tvalid), 32'd0);
    check("rst_tlast", 32'(o_tlast), 32'd0);
    check("rst_tdata", o_tdata, 32'h0);
    check("rst_fcnt", 32'(frame_count), 32'd0);
    @(posedge clk);
    #1;

    // Peak (3,4) at idx 5, latency of two cycles from the last beat
    zero_frame();
    frm[5] = 32'h0003_0004;
    send_frame(8, 1'b1);
    @(negedge clk);
    check("t1_k1_tvalid", 32'(o_tvalid), 32'd0);
    check("t1_k1_tready", 32'(i_tready), 32'd0);
    @(negedge clk);
    check("t1_k2_tvalid", 32'(o_tvalid), 32'd1);
    check("t1_w0", o_tdata, 32'd25);
    check("t1_w0_last", 32'(o_tlast), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t1_w1", o_tdata, 32'h8000_0005);
    check("t1_w1_last", 32'(o_tlast), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("t1_fcnt", 32'(frame_count), 32'd1);
    check("t1_idle_tvalid", 32'(o_tvalid), 32'd0);
    check("t1_idle_tready", 32'(i_tready), 32'd1);
    @(posedge clk);
    #1;

    // Tie between idx 1 and 2: first occurrence wins
    pulse_clear();
    seq_len = 10'd4; threshold = 32'd100;
    zero_frame();
    frm[0] = 32'h0003_0000; frm[1] = 32'h0004_0000;
    frm[2] = 32'h0000_0004; frm[3] = 32'h0002_0000;
    send_frame(4, 1'b1);
    recv("t2", w0, w1);
    check("t2_w0", w0, 32'd16);
    check("t2_w1", w1, 32'h0000_0001);

    // Early tlast, then a clean frame, then missing tlast with seq_len changed mid-frame
    pulse_clear();
    seq_len = 10'd8;
    zero_frame();
    frm[1] = 32'h0005_0000;
    send_frame(3, 1'b1);
    recv("t3a", w0, w1);
    check("t3a_w0", w0, 32'd25);
    check("t3a_w1", w1, 32'h4000_0001);
    zero_frame();
    frm[0] = 32'h0001_0000; frm[6] = 32'h0000_0002;
    send_frame(8, 1'b1);
    recv("t3b", w0, w1);
    check("t3b_w0", w0, 32'd4);
    check("t3b_w1", w1, 32'h0000_0406);
    seq_len = 10'd4;
    send(32'h0, 1'b0);
    seq_len = 10'd2;
    send(32'h0, 1'b0);
    send(32'h0000_0003, 1'b0);
    send(32'h0, 1'b0);
    recv("t3c", w0, w1);
    check("t3c_w0", w0, 32'd9);
    check("t3c_w1", w1, 32'h4000_0802);

    // Extreme sample and all-zero frame with zero threshold
    seq_len = 10'd1; threshold = 32'h7FFF_FFFF;
    send(32'h8000_8000, 1'b1);
    recv("t4a", w0, w1);
    check("t4a_w0", w0, 32'h8000_0000);
    check("t4a_w1", w1, 32'h8000_0C00);
    threshold = 32'd0;
    send(32'h0, 1'b1);
    recv("t4b", w0, w1);
    check("t4b_w0", w0, 32'h0);
    check("t4b_w1", w1, 32'h0000_1000);

    // Output backpressure with input valid held high
    seq_len = 10'd2; threshold = 32'd100; o_tready = 1'b0;
    send(32'h0000_0001, 1'b0);
    send(32'h0002_0000, 1'b1);
    i_tdata = 32'h0000_0003; i_tlast = 1'b0; i_tvalid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("t5_stall_tready", 32'(i_tready), 32'd0);
      if (c > 0) begin
        check("t5_stall_tvalid", 32'(o_tvalid), 32'd1);
        check("t5_stall_tdata", o_tdata, 32'd4);
      end
    end
    o_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_w1", o_tdata, 32'h0000_1401);
    check("t5_w1_last", 32'(o_tlast), 32'd1);
    check("t5_w1_tready", 32'(i_tready), 32'd0);
    @(posedge clk);
    #1;
    send(32'h0000_0003, 1'b0);
    send(32'h0, 1'b1);
    recv("t5n", w0, w1);
    check("t5n_w0", w0, 32'd9);
    check("t5n_w1", w1, 32'h0000_1800);
    check("t5_fcnt", 32'(frame_count), 32'd7);

    // Clear mid-frame abandons it
    seq_len = 10'd8; threshold = 32'd20;
    send(32'h0, 1'b0);
    send(32'h0064_0000, 1'b0);
    send(32'h0, 1'b0);
    pulse_clear();
    @(negedge clk);
    check("t6_clr_fcnt", 32'(frame_count), 32'd0);
    check("t6_clr_tready", 32'(i_tready), 32'd1);
    repeat (3) @(negedge clk);
    check("t6_clr_tvalid", 32'(o_tvalid), 32'd0);
    @(posedge clk);
    #1;
    zero_frame();
    frm[4] = 32'h0000_0005; frm[7] = 32'h0005_0000;
    send_frame(8, 1'b1);
    recv("t6", w0, w1);
    check("t6_w0", w0, 32'd25);
    check("t6_w1", w1, 32'h8000_0004);

    // Full-size frame (seq_len=0 means 1024 beats), peak on the last beat
    seq_len = 10'd0;
    zero_frame();
    frm[500] = 32'h0007_0000; frm[1023] = 32'h0008_0000;
    send_frame(1024, 1'b1);
    recv("t7", w0, w1);
    check("t7_w0", w0, 32'd64);
    check("t7_w1", w1, 32'h8000_07FF);
    @(negedge clk);
    check("t7_fcnt", 32'(frame_count), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
